// File: rtl/axis_pkt_rr_arbiter_pkg.sv
// Shared definitions for the AXIS packet arbiter slice: default bus width,
// FSM state encoding and a width helper for schedulers built on rr_pick.
package axis_pkg;

  localparam int AXIS_TDATA_WIDTH = 256;

  // Two-state packet FSM: waiting for a requester, or forwarding one packet.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Number of bits needed to index 'value' items (minimum 1).
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/axis_pkt_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: given a request vector and the index of
// the last winner, returns the first requester searching ptr+1, ptr+2, ...
// modulo N, as both an index and a one-hot grant. The caller must keep
// i_ptr below N.
module rr_pick
  import axis_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx,
  output logic [N-1:0]     o_grant
);

  localparam int SLOTS = 2 ** IDX_W;

  // Requests padded to the full index range so an IDX_W-bit index never
  // selects outside the vector; the padding slots never request.
  logic [SLOTS-1:0] w_req_pad;
  logic [IDX_W-1:0] w_cand [N];

  assign w_req_pad = SLOTS'(i_req);

  // Candidate k is the port (ptr + 1 + k) mod N, i.e. k-th in search order.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IDX_W:0] w_sum;
    assign w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(gi + 1);
    assign w_cand[gi] = (w_sum >= (IDX_W + 1)'(N)) ? (w_sum[IDX_W-1:0] - IDX_W'(N))
                                                     : w_sum[IDX_W-1:0];
  end

  // Scan farthest candidate first so the nearest requester is the final write.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_req_pad[w_cand[k]]) begin
        o_any = 1'b1;
        o_idx = w_cand[k];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign o_grant[gi] = o_any && (o_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream sink between
// NUM_PORTS sources. A grant is taken in IDLE, held for exactly one packet
// (until the TLAST handshake), then released for one idle cycle before the
// next arbitration. Data is a pure combinational mux of the granted port.
module axis_pkt_rr_arbiter
  import axis_pkg::*;
#(
  parameter int TDATA_WIDTH = AXIS_TDATA_WIDTH,
  parameter int NUM_PORTS   = 4,
  parameter int IDX_W       = 3   // 2**IDX_W must be >= NUM_PORTS
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [NUM_PORTS-1:0]                   S_AXIS_TVALID,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0]       S_AXIS_TDATA,
  input  logic [NUM_PORTS*(TDATA_WIDTH/8)-1:0]   S_AXIS_TKEEP,
  input  logic [NUM_PORTS-1:0]                   S_AXIS_TLAST,
  output logic [NUM_PORTS-1:0]                   S_AXIS_TREADY,
  output logic                                   M_AXIS_TVALID,
  output logic [TDATA_WIDTH-1:0]                 M_AXIS_TDATA,
  output logic [TDATA_WIDTH/8-1:0]               M_AXIS_TKEEP,
  output logic                                   M_AXIS_TLAST,
  input  logic                                   M_AXIS_TREADY,
  output logic [NUM_PORTS-1:0]                   GRANT,
  output logic                                   BUSY,
  output logic [31:0]                            PKT_CNT
);

  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int SLOTS  = 2 ** IDX_W;

  logic [0:0]           r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_gnt_idx;
  logic [NUM_PORTS-1:0] r_grant;
  logic [31:0]          r_pkt_cnt;

  // Per-port views of the flattened buses, padded to the full index range so
  // the grant index can select without range issues; padding slots are idle.
  logic [TDATA_WIDTH-1:0] w_tdata [SLOTS];
  logic [KEEP_W-1:0]      w_tkeep [SLOTS];
  logic [SLOTS-1:0]       w_tvalid;
  logic [SLOTS-1:0]       w_tlast;

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    if (gi < NUM_PORTS) begin : g_port
      assign w_tdata[gi]  = S_AXIS_TDATA[gi*TDATA_WIDTH +: TDATA_WIDTH];
      assign w_tkeep[gi]  = S_AXIS_TKEEP[gi*KEEP_W +: KEEP_W];
      assign w_tvalid[gi] = S_AXIS_TVALID[gi];
      assign w_tlast[gi]  = S_AXIS_TLAST[gi];
    end else begin : g_pad
      assign w_tdata[gi]  = '0;
      assign w_tkeep[gi]  = '0;
      assign w_tvalid[gi] = 1'b0;
      assign w_tlast[gi]  = 1'b0;
    end
  end

  logic                 w_busy;
  logic                 w_sel_tvalid;
  logic                 w_sel_tlast;
  logic                 w_last_hs;
  logic                 w_pick_any;
  logic [IDX_W-1:0]     w_pick_idx;
  logic [NUM_PORTS-1:0] w_pick_grant;

  rr_pick #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (S_AXIS_TVALID),
    .i_ptr   (r_ptr),
    .o_any   (w_pick_any),
    .o_idx   (w_pick_idx),
    .o_grant (w_pick_grant)
  );

  assign w_busy       = (r_state == ST_BUSY);
  assign w_sel_tvalid = w_tvalid[r_gnt_idx];
  assign w_sel_tlast  = w_tlast[r_gnt_idx];
  assign w_last_hs    = w_busy && w_sel_tvalid && M_AXIS_TREADY && w_sel_tlast;

  // Outputs are gated by BUSY so the sink sees a quiet bus while idle even
  // though r_gnt_idx still holds the previous winner.
  assign M_AXIS_TVALID = w_busy && w_sel_tvalid;
  assign M_AXIS_TLAST  = w_busy && w_sel_tlast;
  assign M_AXIS_TDATA  = w_busy ? w_tdata[r_gnt_idx] : '0;
  assign M_AXIS_TKEEP  = w_busy ? w_tkeep[r_gnt_idx] : '0;
  assign S_AXIS_TREADY = r_grant & {NUM_PORTS{M_AXIS_TREADY}};
  assign GRANT         = r_grant;
  assign BUSY          = w_busy;
  assign PKT_CNT       = r_pkt_cnt;

  // Packet FSM: grant on any request in IDLE, release on the TLAST handshake.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state   <= ST_IDLE;
      r_ptr     <= IDX_W'(NUM_PORTS - 1);
      r_gnt_idx <= '0;
      r_grant   <= '0;
      r_pkt_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_state   <= ST_BUSY;
            r_gnt_idx <= w_pick_idx;
            r_grant   <= w_pick_grant;
          end
        end
        ST_BUSY: begin
          if (w_last_hs) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_ptr     <= r_gnt_idx;
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Bench for axis_pkt_rr_arbiter: per-port source queues drive the slave
// side, expected sink beats are queued by the stimulus in hand-worked grant
// order, and a monitor compares every handshaked output beat.
module tb_axis_pkt_rr_arbiter;

  localparam int W = 256;
  localparam int K = W / 8;
  localparam int N = 4;

  logic             ACLK = 1'b0;
  logic             ARESETN = 1'b0;
  logic [N-1:0]     S_AXIS_TVALID;
  logic [N*W-1:0]   S_AXIS_TDATA;
  logic [N*K-1:0]   S_AXIS_TKEEP;
  logic [N-1:0]     S_AXIS_TLAST;
  logic [N-1:0]     S_AXIS_TREADY;
  logic             M_AXIS_TVALID;
  logic [W-1:0]     M_AXIS_TDATA;
  logic [K-1:0]     M_AXIS_TKEEP;
  logic             M_AXIS_TLAST;
  logic             M_AXIS_TREADY;
  logic [N-1:0]     GRANT;
  logic             BUSY;
  logic [31:0]      PKT_CNT;

  axis_pkt_rr_arbiter #(.TDATA_WIDTH(W), .NUM_PORTS(N), .IDX_W(3)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TKEEP(S_AXIS_TKEEP), .S_AXIS_TLAST(S_AXIS_TLAST),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .GRANT(GRANT), .BUSY(BUSY), .PKT_CNT(PKT_CNT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [W-1:0] data;
    logic [K-1:0] keep;
    logic         last;
  } beat_t;

  typedef struct packed {
    beat_t        b;
    logic [N-1:0] gnt;
  } exp_t;

  beat_t src_q [N][$];
  exp_t  sb_q [$];
  int    checks = 0;
  int    failures = 0;

  function automatic beat_t mk_beat(int port, int pkt, int idx, bit last);
    beat_t       b;
    logic [31:0] tag;
    tag    = {8'hA5, 8'(port), 8'(pkt), 8'(idx)};
    b.data = {8{tag}};
    b.keep = last ? {{(K/2){1'b0}}, {(K/2){1'b1}}} : {K{1'b1}};
    b.last = last;
    return b;
  endfunction

  function automatic logic [31:0] tag_of(int port, int pkt, int idx);
    return {8'hA5, 8'(port), 8'(pkt), 8'(idx)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Queue nbeats on a source; only the first nexp beats are expected at the sink.
  task automatic load_pkt(input int port, input int pkt, input int nbeats, input int nexp);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < nbeats; i++) begin
      b = mk_beat(port, pkt, i, (i == nbeats - 1));
      src_q[port].push_back(b);
      if (i < nexp) begin
        e.b   = b;
        e.gnt = N'(1) << port;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic drive_srcs();
    for (int p = 0; p < N; p++) begin
      if (src_q[p].size() > 0) begin
        S_AXIS_TVALID[p]       = 1'b1;
        S_AXIS_TDATA[p*W +: W] = src_q[p][0].data;
        S_AXIS_TKEEP[p*K +: K] = src_q[p][0].keep;
        S_AXIS_TLAST[p]        = src_q[p][0].last;
      end else begin
        S_AXIS_TVALID[p]       = 1'b0;
        S_AXIS_TDATA[p*W +: W] = '0;
        S_AXIS_TKEEP[p*K +: K] = '0;
        S_AXIS_TLAST[p]        = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      if (sb_q.size() == 0 && !BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  // Source driver: a handshake seen at the negedge completes on the next edge.
  initial begin
    logic [N-1:0] hs_pend;
    forever begin
      @(negedge ACLK);
      hs_pend = S_AXIS_TVALID & S_AXIS_TREADY;
      @(posedge ACLK);
      #1;
      for (int p = 0; p < N; p++) begin
        if (hs_pend[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      end
      drive_srcs();
    end
  end

  // Monitor: every sink handshake must match the next expected beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got tag %0h with nothing expected", M_AXIS_TDATA[31:0]);
        end else begin
          e = sb_q.pop_front();
          checks++;
          if ({M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST} !== e.b) begin
            failures++;
            $display("FAIL beat: got tag %0h keep %0h last %0b expected tag %0h keep %0h last %0b",
                     M_AXIS_TDATA[31:0], M_AXIS_TKEEP, M_AXIS_TLAST,
                     e.b.data[31:0], e.b.keep, e.b.last);
          end else begin
            $display("beat tag %0h last %0b grant %b", M_AXIS_TDATA[31:0], M_AXIS_TLAST, GRANT);
          end
          chk("beat_grant_tready", {56'd0, GRANT, S_AXIS_TREADY}, {56'd0, e.gnt, e.gnt});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  idle_c;
    int  busy_c;
    bit  ok;
    bit  pat [5];

    M_AXIS_TREADY = 1'b1;
    ARESETN       = 1'b0;
    drive_srcs();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_grant", 64'(GRANT), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_pkt_cnt", 64'(PKT_CNT), 64'd0);
    chk("rst_outputs", {61'd0, M_AXIS_TVALID, M_AXIS_TLAST, (M_AXIS_TDATA != '0)}, 64'd0);

    // Test 1: port0 3-beat packet.
    @(posedge ACLK); #1; ARESETN = 1'b1;
    @(posedge ACLK); #1; load_pkt(0, 0, 3, 3); drive_srcs();
    @(negedge ACLK);
    chk("t1_idle_no_grant", {56'd0, GRANT, S_AXIS_TREADY}, 64'd0);
    chk("t1_idle_m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    @(negedge ACLK);
    chk("t1_grant", 64'(GRANT), 64'b0001);
    chk("t1_busy", 64'(BUSY), 64'd1);
    wait_idle("t1_done", 20);
    chk("t1_pkt_cnt", 64'(PKT_CNT), 64'd1);
    chk("t1_grant_cleared", 64'(GRANT), 64'd0);

    // Test 2: reset, then all ports send two 2-beat packets each.
    @(posedge ACLK); #1; ARESETN = 1'b0;
    @(posedge ACLK); #1; ARESETN = 1'b1;
    @(posedge ACLK); #1;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < N; p++) load_pkt(p, k, 2, 2);
    drive_srcs();
    n = 0; idle_c = 0; busy_c = 0;
    while (n < 100) begin
      @(negedge ACLK);
      if (PKT_CNT == 32'd8) break;
      n++;
      if (BUSY) busy_c++; else idle_c++;
    end
    chk("t2_cycles", 64'(n), 64'd24);
    chk("t2_idle_bubbles", 64'(idle_c), 64'd8);
    chk("t2_busy_cycles", 64'(busy_c), 64'd16);
    chk("t2_pkt_cnt", 64'(PKT_CNT), 64'd8);
    chk("t2_sb_drained", 64'(sb_q.size()), 64'd0);

    // Test 3: port1 requests while port2 is mid-packet; search 3,0,1 after.
    @(posedge ACLK); #1; load_pkt(2, 5, 4, 4); drive_srcs();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin ok = 1'b1; break; end
    end
    chk("t3_first_beat_seen", 64'(ok), 64'd1);
    @(posedge ACLK); #1; load_pkt(1, 5, 2, 2); drive_srcs();
    @(negedge ACLK);
    chk("t3_grant_held_a", 64'(GRANT), 64'b0100);
    @(negedge ACLK);
    chk("t3_grant_held_b", 64'(GRANT), 64'b0100);
    wait_idle("t3_done", 30);
    chk("t3_pkt_cnt", 64'(PKT_CNT), 64'd10);

    // Test 4: sink ready pattern 1,0,0,1,1,1 over a 4-beat port3 packet.
    @(posedge ACLK); #1; load_pkt(3, 6, 4, 4); drive_srcs();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (GRANT != '0) begin ok = 1'b1; break; end
    end
    chk("t4_granted", 64'(ok), 64'd1);
    chk("t4_tready_c0", 64'(S_AXIS_TREADY), 64'b1000);
    pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      @(posedge ACLK); #1; M_AXIS_TREADY = pat[k];
      @(negedge ACLK);
      chk("t4_tready_mirror", 64'(S_AXIS_TREADY), pat[k] ? 64'b1000 : 64'd0);
      if (!pat[k]) begin
        chk("t4_stall_data", {31'd0, M_AXIS_TVALID, M_AXIS_TDATA[31:0]},
            {31'd0, 1'b1, tag_of(3, 6, 1)});
      end
    end
    M_AXIS_TREADY = 1'b1;
    wait_idle("t4_done", 20);
    chk("t4_pkt_cnt", 64'(PKT_CNT), 64'd11);

    // Test 5: single-beat packet on port0, then abort a port1 packet by reset.
    @(posedge ACLK); #1; load_pkt(0, 7, 1, 1); drive_srcs();
    n = 0; busy_c = 0;
    while (n < 20) begin
      @(negedge ACLK);
      if (PKT_CNT == 32'd12) break;
      n++;
      if (BUSY) busy_c++;
    end
    chk("t5_single_beat_busy", 64'(busy_c), 64'd1);
    chk("t5_pkt_cnt_pre", 64'(PKT_CNT), 64'd12);
    @(posedge ACLK); #1; load_pkt(1, 0, 4, 2); drive_srcs();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TDATA[31:0] == tag_of(1, 0, 1)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_beat2_seen", 64'(ok), 64'd1);
    @(posedge ACLK); #2;
    ARESETN = 1'b0;
    M_AXIS_TREADY = 1'b0;
    src_q[1].delete();
    drive_srcs();
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    M_AXIS_TREADY = 1'b1;
    load_pkt(0, 8, 1, 1);
    load_pkt(1, 8, 1, 1);
    drive_srcs();
    @(negedge ACLK);
    chk("t5_rst_grant", 64'(GRANT), 64'd0);
    chk("t5_rst_busy", 64'(BUSY), 64'd0);
    chk("t5_rst_pkt_cnt", 64'(PKT_CNT), 64'd0);
    wait_idle("t5_done", 20);
    chk("t5_pkt_cnt_post", 64'(PKT_CNT), 64'd2);

    // Test 6: counter wrap from all-ones.
    @(negedge ACLK);
    force dut.r_pkt_cnt = 32'hFFFF_FFFF;
    @(posedge ACLK); #1;
    release dut.r_pkt_cnt;
    @(negedge ACLK);
    chk("t6_preload", 64'(PKT_CNT), 64'hFFFF_FFFF);
    @(posedge ACLK); #1; load_pkt(2, 9, 1, 1); drive_srcs();
    wait_idle("t6_done", 20);
    chk("t6_wrap", 64'(PKT_CNT), 64'd0);

    @(negedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
